// File: rtl/ipf_res_collector.sv
// ipf_res_collector
//   Downstream stage of the IPF compute core. IPF cannot be stalled, so every
//   result word is captured into a FIFO. The words are then replayed as a
//   valid/ready write stream with sequential addresses. Finish is tracked, and
//   done is raised once every captured word has been written out.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous frame clear (highest priority)
//   res_valid  IPF result strobe, res = result word
//   finish     IPF end-of-run (pulse or level)
//   o_valid    write word available (FIFO not empty)
//   o_data     write data (FIFO head, 0 when empty)
//   o_addr     write address = pops this frame, wraps
//   o_ready    memory accepts the word this cycle
//   res_cnt    results accepted this frame, saturating
//   overflow   sticky: a result word was dropped
//   done       frame complete (registered)
module ipf_res_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res,
  input  logic              finish,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  input  logic              o_ready,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              overflow,
  output logic              done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PW:0]       r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic [1:0]        r_state;

  logic              w_full, w_empty, w_push, w_pop;
  logic [PW:0]       w_count_nxt;
  logic [1:0]        w_state_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = !w_empty && o_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push  = res_valid && (!w_full || w_pop) && (r_state != S_DONE) && !clr;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (finish) w_state_nxt = S_DRAIN;
               else if (w_push) w_state_nxt = S_RUN;
      S_RUN:   if (finish) w_state_nxt = S_DRAIN;
      // A word arriving while draining keeps us out of DONE for this cycle.
      S_DRAIN: if ((w_count_nxt == '0) && !w_push) w_state_nxt = S_DONE;
      default: w_state_nxt = r_state;
    endcase
  end

  // Storage needs no reset: an empty FIFO masks o_data to zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_state  <= S_IDLE;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_state  <= S_IDLE;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_addr + 1'b1;
      end
      // Dropped either because full without a pop, or because the frame is done.
      if (res_valid && !w_push) r_ovf <= 1'b1;
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign o_valid  = !w_empty;
  assign o_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_addr   = r_addr;
  assign res_cnt  = r_cnt;
  assign overflow = r_ovf;
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_ipf_res_collector.sv
module tb_ipf_res_collector;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 5;
  localparam int AMOD   = 1 << ADDR_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, res_valid = 1'b0, finish = 1'b0, o_ready = 1'b0;
  logic [DATA_W-1:0] res = '0, o_data;
  logic o_valid, overflow, done;
  logic [ADDR_W-1:0] o_addr;
  logic [CNT_W-1:0] res_cnt;

  ipf_res_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .res_valid(res_valid), .res(res), .finish(finish),
    .o_valid(o_valid), .o_data(o_data), .o_addr(o_addr), .o_ready(o_ready),
    .res_cnt(res_cnt), .overflow(overflow), .done(done));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // reference model: queue of pending words plus frame bookkeeping
  logic [DATA_W-1:0] m_q[$];
  int m_addr, m_cnt;
  bit m_ovf, m_fin, m_done;
  int exp_a[$], obs_a[$];
  logic [DATA_W-1:0] exp_d[$], obs_d[$];

  // snapshot of DUT outputs and of model before each clock edge
  logic cur_valid, cur_ovf, cur_done;
  logic [DATA_W-1:0] cur_data;
  int cur_addr, cur_cnt;
  bit pre_valid, pre_ovf, pre_done;
  logic [DATA_W-1:0] pre_head;
  int pre_addr, pre_cnt;

  task automatic model_reset();
    m_q.delete(); m_addr = 0; m_cnt = 0; m_ovf = 0; m_fin = 0; m_done = 0;
    exp_a.delete(); exp_d.delete(); obs_a.delete(); obs_d.delete();
  endtask

  task automatic cyc(input bit rv, input logic [DATA_W-1:0] d, input bit fin, input bit rdy, input bit cl);
    bit popped, pushed, nd;
    @(negedge clk);
    res_valid = rv; res = d; finish = fin; o_ready = rdy; clr = cl;
    #1;
    cur_valid = o_valid; cur_data = o_data; cur_addr = int'(o_addr);
    cur_cnt = int'(res_cnt); cur_ovf = overflow; cur_done = done;
    pre_valid = (m_q.size() > 0); pre_head = pre_valid ? m_q[0] : '0;
    pre_addr = m_addr % AMOD; pre_cnt = m_cnt; pre_ovf = m_ovf; pre_done = m_done;
    if (o_valid && rdy && !cl) begin obs_a.push_back(int'(o_addr)); obs_d.push_back(o_data); end
    @(posedge clk);
    if (cl) begin
      m_q.delete(); m_addr = 0; m_cnt = 0; m_ovf = 0; m_fin = 0; m_done = 0;
    end else begin
      popped = (m_q.size() > 0) && rdy;
      pushed = rv && !m_done && ((m_q.size() < DEPTH) || popped);
      if (popped) begin
        exp_a.push_back(m_addr % AMOD); exp_d.push_back(m_q.pop_front()); m_addr++;
      end
      if (pushed) begin
        m_q.push_back(d);
        if (m_cnt < CMAX) m_cnt++;
      end
      if (rv && !pushed) m_ovf = 1;
      nd = m_done || (m_fin && (m_q.size() == 0) && !pushed);
      if (fin) m_fin = 1;
      m_done = nd;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({o_valid, overflow, done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {o_valid, overflow, done}); end
    n_cmp++; if (o_addr !== '0 || res_cnt !== '0 || o_data !== '0) begin n_bad++; $display("FAIL reset_regs: addr %0h cnt %0h data %0h want 0", o_addr, res_cnt, o_data); end
    @(negedge clk); rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int k;
    cyc(0, 0, 0, 1, 1); model_reset();
    for (int i = 1; i <= 12; i++) cyc(1, DATA_W'(i), 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    k = 0;
    while (!m_done && k < 20) begin cyc(0, 0, 0, 1, 0); k++; end
    cyc(0, 0, 0, 1, 0);
    n_cmp++; if (cur_done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", cur_done); end
    n_cmp++; if (cur_cnt !== 12) begin n_bad++; $display("FAIL basic_cnt: got %0d want 12", cur_cnt); end
    n_cmp++; if (cur_ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", cur_ovf); end
    n_cmp++;
    if (obs_a.size() != 12) begin n_bad++; $display("FAIL basic_nwr: got %0d want 12", obs_a.size()); end
    else for (int i = 0; i < 12; i++)
      if (obs_a[i] != i || obs_d[i] !== DATA_W'(i + 1)) begin
        n_bad++; $display("FAIL basic_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, obs_a[i], obs_d[i], i, i + 1); break;
      end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] w[17];
    cyc(0, 0, 0, 0, 1); model_reset();
    for (int i = 0; i < 17; i++) begin w[i] = $urandom; cyc(1, w[i], 0, 0, 0); end
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (cur_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", cur_ovf); end
    n_cmp++; if (cur_cnt !== 16) begin n_bad++; $display("FAIL ovf_cnt: got %0d want 16", cur_cnt); end
    for (int i = 0; i < 18; i++) cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (obs_a.size() != 16) begin n_bad++; $display("FAIL ovf_nwr: got %0d want 16", obs_a.size()); end
    else for (int i = 0; i < 16; i++)
      if (obs_a[i] != i || obs_d[i] !== w[i]) begin
        n_bad++; $display("FAIL ovf_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, obs_a[i], obs_d[i], i, w[i]); break;
      end
  endtask

  task automatic test_full_pushpop();
    logic [DATA_W-1:0] w[20];
    int pre_drain;
    cyc(0, 0, 0, 0, 1); model_reset();
    for (int i = 0; i < 20; i++) w[i] = $urandom;
    for (int i = 0; i < 16; i++) cyc(1, w[i], 0, 0, 0);
    for (int i = 16; i < 20; i++) cyc(1, w[i], 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    n_cmp++; if (cur_ovf !== 1'b0) begin n_bad++; $display("FAIL full_ovf: got %b want 0", cur_ovf); end
    n_cmp++; if (cur_cnt !== 20) begin n_bad++; $display("FAIL full_cnt: got %0d want 20", cur_cnt); end
    pre_drain = obs_a.size();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);
    n_cmp++; if (obs_a.size() - pre_drain != 16) begin n_bad++; $display("FAIL full_occ: got %0d want 16", obs_a.size() - pre_drain); end
    n_cmp++;
    if (obs_a.size() != 20) begin n_bad++; $display("FAIL full_nwr: got %0d want 20", obs_a.size()); end
    else for (int i = 0; i < 20; i++)
      if (obs_a[i] != i || obs_d[i] !== w[i]) begin
        n_bad++; $display("FAIL full_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, obs_a[i], obs_d[i], i, w[i]); break;
      end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] w[8];
    bit p_stall, rdy;
    logic [DATA_W-1:0] p_data;
    int p_addr, k, bad;
    cyc(0, 0, 0, 0, 1); model_reset();
    p_stall = 0; bad = 0; k = 0;
    while (obs_a.size() < 8 && k < 40) begin
      rdy = (k % 2 == 0);
      if (k < 8) begin w[k] = $urandom; cyc(1, w[k], 0, rdy, 0); end
      else cyc(0, 0, 0, rdy, 0);
      if (p_stall && (cur_data !== p_data || cur_addr != p_addr)) bad++;
      p_stall = cur_valid && !rdy; p_data = cur_data; p_addr = cur_addr;
      k++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
    n_cmp++;
    if (obs_a.size() != 8) begin n_bad++; $display("FAIL stall_nwr: got %0d want 8", obs_a.size()); end
    else for (int i = 0; i < 8; i++)
      if (obs_a[i] != i || obs_d[i] !== w[i]) begin
        n_bad++; $display("FAIL stall_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, obs_a[i], obs_d[i], i, w[i]); break;
      end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] w[3];
    int k;
    cyc(0, 0, 0, 0, 1); model_reset();
    for (int i = 0; i < 4; i++) cyc(1, DATA_W'($urandom), (i == 3), 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(posedge clk); #3;
    rst = 1'b0; res_valid = 1'b0; finish = 1'b0; o_ready = 1'b1;
    #1;
    n_cmp++; if ({o_valid, overflow, done} !== 3'b000) begin n_bad++; $display("FAIL arst_flags: got %b want 000", {o_valid, overflow, done}); end
    n_cmp++; if (o_addr !== '0 || res_cnt !== '0 || o_data !== '0) begin n_bad++; $display("FAIL arst_regs: addr %0h cnt %0h data %0h want 0", o_addr, res_cnt, o_data); end
    @(posedge clk); #2; rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin w[i] = $urandom; cyc(1, w[i], (i == 2), 1, 0); end
    k = 0;
    while (!m_done && k < 20) begin cyc(0, 0, 0, 1, 0); k++; end
    cyc(0, 0, 0, 1, 0);
    n_cmp++; if (cur_done !== 1'b1) begin n_bad++; $display("FAIL arst_done: got %b want 1", cur_done); end
    n_cmp++;
    if (obs_a.size() != 3) begin n_bad++; $display("FAIL arst_nwr: got %0d want 3", obs_a.size()); end
    else for (int i = 0; i < 3; i++)
      if (obs_a[i] != i || obs_d[i] !== w[i]) begin
        n_bad++; $display("FAIL arst_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, obs_a[i], obs_d[i], i, w[i]); break;
      end
  endtask

  task automatic test_done_clr();
    logic [DATA_W-1:0] w[5];
    int k;
    cyc(1, 32'hDEAD, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    n_cmp++; if (cur_ovf !== 1'b1) begin n_bad++; $display("FAIL done_ovf: got %b want 1", cur_ovf); end
    n_cmp++; if (cur_cnt !== 3 || cur_valid !== 1'b0) begin n_bad++; $display("FAIL done_ignore: cnt %0d valid %b want 3 0", cur_cnt, cur_valid); end
    cyc(0, 0, 0, 1, 1); model_reset();
    cyc(0, 0, 0, 1, 0);
    n_cmp++; if ({cur_done, cur_ovf} !== 2'b00) begin n_bad++; $display("FAIL clr_flags: got %b want 00", {cur_done, cur_ovf}); end
    n_cmp++; if (cur_addr != 0 || cur_cnt != 0) begin n_bad++; $display("FAIL clr_regs: addr %0d cnt %0d want 0 0", cur_addr, cur_cnt); end
    for (int i = 0; i < 5; i++) begin w[i] = $urandom; cyc(1, w[i], 0, 1, 0); end
    cyc(0, 0, 1, 1, 0);
    k = 0;
    while (!m_done && k < 20) begin cyc(0, 0, 0, 1, 0); k++; end
    cyc(0, 0, 0, 1, 0);
    n_cmp++; if (cur_done !== 1'b1 || cur_cnt != 5) begin n_bad++; $display("FAIL clr_frame: done %b cnt %0d want 1 5", cur_done, cur_cnt); end
    n_cmp++;
    if (obs_a.size() != 5) begin n_bad++; $display("FAIL clr_nwr: got %0d want 5", obs_a.size()); end
    else for (int i = 0; i < 5; i++)
      if (obs_a[i] != i || obs_d[i] !== w[i]) begin
        n_bad++; $display("FAIL clr_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, obs_a[i], obs_d[i], i, w[i]); break;
      end
  endtask

  task automatic test_random();
    int bad;
    bit fin, cl;
    cyc(0, 0, 0, 0, 1); model_reset();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      fin = (c > 250) && ($urandom_range(0, 40) == 0);
      cl  = (c == 400);
      cyc(($urandom_range(0, 3) != 0), DATA_W'($urandom), fin, ($urandom_range(0, 2) != 0), cl);
      if (cur_valid !== pre_valid || (pre_valid && cur_data !== pre_head) || cur_addr != pre_addr ||
          cur_cnt != pre_cnt || cur_ovf !== pre_ovf || cur_done !== pre_done) begin
        if (bad == 0)
          $display("FAIL rand_cycle%0d: got v%b d%0h a%0d c%0d o%b dn%b want v%b d%0h a%0d c%0d o%b dn%b",
                   c, cur_valid, cur_data, cur_addr, cur_cnt, cur_ovf, cur_done,
                   pre_valid, pre_head, pre_addr, pre_cnt, pre_ovf, pre_done);
        bad++;
      end
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rand_cycles: got %0d bad cycles want 0", bad); end
    n_cmp++;
    if (obs_a.size() != exp_a.size()) begin n_bad++; $display("FAIL rand_nwr: got %0d want %0d", obs_a.size(), exp_a.size()); end
    else for (int i = 0; i < exp_a.size(); i++)
      if (obs_a[i] != exp_a[i] || obs_d[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL rand_wr%0d: got a=%0d d=%0h want a=%0d d=%0h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]); break;
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_stall();
    test_async_reset();
    test_done_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
